// File: rtl/uart_rx_fifo.sv
// Receive-side elastic FIFO between the UART receiver and the AXI-Stream fabric.
// Optional build macro: UART_RX_FIFO_DROP_ERR_EN discards bytes flagged with parity/stop errors.
module uart_rx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [DATA_WIDTH-1:0]   slv_axis_tdata_i,
  input  logic                    slv_axis_tvalid_i,
  input  logic                    slv_axis_tlast_i,
  output logic                    slv_axis_tready_o,
  input  logic                    parity_err_i,
  input  logic                    stop_err_i,
  output logic [DATA_WIDTH-1:0]   mst_axis_tdata_o,
  output logic                    mst_axis_tvalid_o,
  output logic                    mst_axis_tlast_o,
  output logic [1:0]              mst_axis_tuser_o,
  input  logic                    mst_axis_tready_i,
  input  logic                    clr_i,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    overflow_o,
  output logic [15:0]             drop_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = DATA_WIDTH + 3;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] head_idx;
  logic [LW-1:0] level_q;
  logic          overflow_q;
  logic [15:0]   drop_cnt_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;
  logic          ovf_set;
  logic [EW-1:0] head;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign pop   = !empty && mst_axis_tready_i;

`ifdef UART_RX_FIFO_DROP_ERR_EN
  logic beat_err;
  assign beat_err = parity_err_i | stop_err_i;
  assign push     = slv_axis_tvalid_i && !full && !beat_err;
  assign drop     = slv_axis_tvalid_i && (full || beat_err);
  assign ovf_set  = slv_axis_tvalid_i && full;
`else
  assign push     = slv_axis_tvalid_i && !full;
  assign drop     = slv_axis_tvalid_i && full;
  assign ovf_set  = drop;
`endif

  // When empty, show the last popped entry so the data lines hold their value
  assign head_idx = empty ? AW'(rd_ptr_q - AW'(1)) : rd_ptr_q;
  assign head     = mem[head_idx];

  assign mst_axis_tdata_o  = head[DATA_WIDTH-1:0];
  assign mst_axis_tlast_o  = head[EW-1];
`ifdef UART_RX_FIFO_DROP_ERR_EN
  assign mst_axis_tuser_o  = 2'b00;
`else
  assign mst_axis_tuser_o  = head[EW-2:DATA_WIDTH];
`endif
  assign mst_axis_tvalid_o = !empty;
  assign slv_axis_tready_o = !full;
  assign level_o           = level_q;
  assign overflow_o        = overflow_q;
  assign drop_cnt_o        = drop_cnt_q;

  // Storage and pointers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr_q] <= {slv_axis_tlast_i, stop_err_i, parity_err_i, slv_axis_tdata_i};
        wr_ptr_q      <= AW'(wr_ptr_q + AW'(1));
      end
      if (pop) begin
        rd_ptr_q <= AW'(rd_ptr_q + AW'(1));
      end
      case ({push, pop})
        2'b10:   level_q <= LW'(level_q + LW'(1));
        2'b01:   level_q <= LW'(level_q - LW'(1));
        default: level_q <= level_q;
      endcase
    end
  end

  // Drop accounting; a clear in the same cycle as a drop takes priority
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (clr_i) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a queue scoreboard and a small reference model.
module tb_uart_rx_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic          par_err;
  logic          stp_err;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic [1:0]    m_tuser;
  logic          m_tready;
  logic          clr;
  logic [LW-1:0] level;
  logic          overflow;
  logic [15:0]   drop_cnt;

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .slv_axis_tdata_i(s_tdata), .slv_axis_tvalid_i(s_tvalid), .slv_axis_tlast_i(s_tlast),
    .slv_axis_tready_o(s_tready), .parity_err_i(par_err), .stop_err_i(stp_err),
    .mst_axis_tdata_o(m_tdata), .mst_axis_tvalid_o(m_tvalid), .mst_axis_tlast_o(m_tlast),
    .mst_axis_tuser_o(m_tuser), .mst_axis_tready_i(m_tready), .clr_i(clr),
    .level_o(level), .overflow_o(overflow), .drop_cnt_o(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [10:0] sb[$];
  int          m_level = 0;
  logic        m_ovf = 1'b0;
  int          m_drop = 0;
  logic [10:0] last_pop = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic pe,
                       input logic se, input logic rdy, input logic c, input logic rn);
    s_tvalid = v; s_tdata = d; s_tlast = l; par_err = pe; stp_err = se;
    m_tready = rdy; clr = c; rst_n = rn;
  endtask

  // One clock: check handshake outputs before the edge, advance the model, check state after
  task automatic tick();
    logic        exp_v, do_pop, do_push, do_drop, do_ovf, err;
    logic [10:0] e;
    exp_v = (m_level != 0);
    chk("mst_tvalid", 32'(m_tvalid), 32'(exp_v));
    chk("slv_tready", 32'(s_tready), 32'(m_level != int'(DEPTH)));
    do_pop = exp_v && m_tready;
    if (do_pop && sb.size() != 0) begin
      e = sb.pop_front();
      chk("tdata", 32'(m_tdata), 32'(e[7:0]));
      chk("tuser", 32'(m_tuser), 32'(e[9:8]));
      chk("tlast", 32'(m_tlast), 32'(e[10]));
      last_pop = e;
    end
    err = par_err | stp_err;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    do_push = s_tvalid && (m_level != int'(DEPTH)) && !err;
    do_drop = s_tvalid && ((m_level == int'(DEPTH)) || err);
    do_ovf  = s_tvalid && (m_level == int'(DEPTH));
`else
    do_push = s_tvalid && (m_level != int'(DEPTH));
    do_drop = s_tvalid && (m_level == int'(DEPTH));
    do_ovf  = do_drop;
`endif
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_level = 0; m_ovf = 1'b0; m_drop = 0; sb.delete();
    end else begin
      if (do_push) sb.push_back({s_tlast, stp_err, par_err, s_tdata});
      m_level = m_level + int'(do_push) - int'(do_pop);
      if (clr) begin
        m_ovf = 1'b0; m_drop = 0;
      end else begin
        if (do_ovf) m_ovf = 1'b1;
        if (do_drop && m_drop != 16'hFFFF) m_drop++;
      end
    end
    chk("level", 32'(level), 32'(m_level));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  initial begin
    drive(0, 8'h00, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_tuser", 32'(m_tuser), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_slv_tready", 32'(s_tready), 32'd1);

    // Single byte through with the consumer ready
    drive(1, 8'h55, 0, 0, 0, 1, 0, 1); tick();
    drive(0, 8'h00, 0, 0, 0, 1, 0, 1); tick();
    chk("hold_tdata_empty", 32'(m_tdata), 32'h55);

    // Overfill with the consumer stalled, then drain
    for (int i = 0; i < int'(DEPTH) + 3; i++) begin
      drive(1, 8'(i), 0, 0, 0, 0, 0, 1); tick();
    end
    chk("full_drop_cnt", 32'(drop_cnt), 32'd3);
    chk("full_slv_tready", 32'(s_tready), 32'd0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive(0, 8'h00, 0, 0, 0, 1, 0, 1); tick();
    end
    chk("drain_last", 32'(last_pop[7:0]), 32'h0F);

    // Full FIFO: simultaneous push and pop drops the push, then clear
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive(1, 8'(8'h20 + i), 0, 0, 0, 0, 0, 1); tick();
    end
    drive(1, 8'hEE, 0, 0, 0, 1, 0, 1); tick();
    chk("pushpop_full_level", 32'(level), 32'(DEPTH - 1));
    drive(0, 8'h00, 0, 0, 0, 0, 1, 1); tick();
    drive(1, 8'h40, 0, 0, 0, 0, 0, 1); tick();
    // Drop coinciding with clear is not counted
    drive(1, 8'hEF, 0, 0, 0, 0, 1, 1); tick();
    chk("clr_wins_drop", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive(0, 8'h00, 0, 0, 0, 1, 0, 1); tick();
    end
    chk("after_clr_last", 32'(last_pop[7:0]), 32'h40);

    // Errored bytes
    drive(1, 8'hA3, 0, 1, 0, 0, 0, 1); tick();
    drive(1, 8'h3C, 1, 0, 1, 0, 0, 1); tick();
    drive(0, 8'h00, 0, 0, 0, 1, 0, 1); tick(); tick(); tick();

    // Sustained push/pop at level 5 across pointer wrap
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'(8'h80 + i), 0, 0, 0, 0, 0, 1); tick();
    end
    for (int i = 0; i < 3 * int'(DEPTH); i++) begin
      drive(1, 8'(8'h85 + i), 1'(i % 3 == 0), 0, 0, 1, 0, 1); tick();
    end
    chk("wrap_level", 32'(level), 32'd5);

    // Reset mid-stream
    drive(1, 8'h99, 1, 1, 1, 0, 0, 0); tick();
    chk("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("mid_rst_tdata", 32'(m_tdata), 32'd0);
    chk("mid_rst_tlast", 32'(m_tlast), 32'd0);
    chk("mid_rst_tuser", 32'(m_tuser), 32'd0);
    drive(0, 8'h00, 0, 0, 0, 1, 0, 1); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side elastic buffer between the UART receiver and the system AXI-Stream fabric. It accepts every byte the receiver emits as a single-cycle AXI-Stream beat, together with that byte's parity and stop-bit error flags, and stores the byte in a DEPTH-entry FIFO. It presents the stored bytes to the consumer over AXI-Stream with full back-pressure. The receiver cannot stall, so on overflow the block drops bytes, counts them, and raises a sticky flag.

## Interface
- DATA_WIDTH, 8, byte width of stream data
- DEPTH, 16, FIFO entries; power of two, 2..256
- clk_i  in  1  single clock; all logic rising-edge
- rst_n_i  in  1  reset, synchronous and active-low
- slv_axis_tdata_i  in  DATA_WIDTH  received byte
- slv_axis_tvalid_i  in  1  one-cycle strobe per received byte
- slv_axis_tlast_i  in  1  passed through per byte
- slv_axis_tready_o  out  1  high when not full; informational, the producer ignores it
- parity_err_i  in  1  parity error for the byte; sampled with tvalid
- stop_err_i  in  1  stop-bit error for the byte; sampled with tvalid
- mst_axis_tdata_o  out  DATA_WIDTH  head-of-FIFO byte
- mst_axis_tvalid_o  out  1  FIFO not empty
- mst_axis_tlast_o  out  1  stored tlast of the head entry
- mst_axis_tuser_o  out  2  {stop_err, parity_err} of the head entry
- mst_axis_tready_i  in  1  consumer accepts the head entry
- clr_i  in  1  clears overflow_o and drop_cnt_o; FIFO contents unaffected
- level_o  out  $clog2(DEPTH)+1  number of stored entries
- overflow_o  out  1  sticky; set on first dropped byte
- drop_cnt_o  out  16  count of dropped bytes, saturating

## Operation
- Storage: DEPTH entries of {tlast, stop_err, parity_err, tdata}. Write and read pointers are $clog2(DEPTH) bits wide and wrap naturally.
- Push: occurs on slv_axis_tvalid_i=1 when the FIFO is not full at the start of the cycle. A push in the same cycle as a pop does not count as room: if the FIFO is full, the byte is dropped even when a pop occurs in that cycle.
- Drop: a tvalid beat arriving while the FIFO is full is discarded.
  - overflow_o is set.
  - drop_cnt_o increments and saturates at 16'hFFFF.
- Pop: occurs when mst_axis_tvalid_o=1 and mst_axis_tready_i=1. Popping while empty is impossible because tvalid is low.
- Output: mst_axis_* is driven combinationally from the entry at the read pointer.
  - tdata, tlast and tuser are stable while tvalid=1 and tready=0.
  - The data registers hold their previous value when the FIFO is empty.
- level_o: +1 on push only, -1 on pop only, unchanged on push and pop together. Range is 0..DEPTH.
- slv_axis_tready_o = (level_o != DEPTH).
- clr_i: zeroes overflow_o and drop_cnt_o. If a drop occurs in the same cycle as clr_i, clr_i wins, and that drop is neither counted nor flagged.
- Reset (rst_n_i=0 at a clock edge): pointers, level_o, overflow_o, drop_cnt_o, mst_axis_tvalid_o, mst_axis_tlast_o and mst_axis_tuser_o go to 0. mst_axis_tdata_o reads 0 because the storage is cleared. Any stored data and any beat arriving in the reset cycle are lost.

## Timing
- Write latency: a byte pushed at edge N appears on mst_axis_* after edge N, so mst_axis_tvalid_o rises in cycle N+1. There is no same-cycle bypass from input to output.
- Throughput: one push and one pop per cycle, sustained.
- level_o, slv_axis_tready_o, overflow_o and drop_cnt_o are registered or derived from registers, and update on the edge of the causing event.
- Error flags: parity_err_i and stop_err_i are captured only in the tvalid cycle. Their value in any other cycle is ignored.

## Configuration
- UART_RX_FIFO_DROP_ERR_EN
  - Defined: a beat with parity_err_i=1 or stop_err_i=1 is never stored. It increments drop_cnt_o with the same saturation but does not set overflow_o. mst_axis_tuser_o is then always 2'b00.
  - Undefined: errored bytes are stored normally, with their flags in tuser.

## Test plan
- Reset, then push 0x55 with tready_i=1 → tvalid high the next cycle with tdata=0x55 and tuser=0, popped the same cycle, level_o returns to 0.
- Hold tready_i=0 and push DEPTH+3 bytes 0x00..0x12 → level_o=DEPTH, slv_axis_tready_o=0, overflow_o=1, drop_cnt_o=3. With tready_i=1, bytes 0x00..0x0F emerge in order.
- With level_o=DEPTH, apply a push and a pop in the same cycle → push dropped, drop_cnt_o +1, level_o=DEPTH-1. Then assert clr_i → overflow_o=0 and drop_cnt_o=0, contents intact.
- Push 0xA3 with parity_err_i=1 and 0x3C with stop_err_i=1 and tlast=1 → without the macro, tuser=2'b01 then 2'b10 and tlast=1 on the second byte. With UART_RX_FIFO_DROP_ERR_EN, nothing stored, drop_cnt_o=2, overflow_o=0.
- Continuous push and pop at level 5 for 3×DEPTH cycles to exercise pointer wrap → level_o stays 5, data order preserved. Assert rst_n_i mid-stream → all outputs 0 on the next edge.
